// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter steering four requesters through a shared 4:1 mux into a
// one-entry valid/ready output register. Define ARB_BURST_EN for burst grants.
module rr_mux_arbiter #(
    parameter int W         = 4,
    parameter int MAX_BURST = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [3:0]   req,
    input  logic [W-1:0] d0,
    input  logic [W-1:0] d1,
    input  logic [W-1:0] d2,
    input  logic [W-1:0] d3,
    output logic [3:0]   gnt,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic [1:0]   out_src
);

    if (MAX_BURST < 1 || MAX_BURST > 15) begin : g_bad_burst
        $error("rr_mux_arbiter: MAX_BURST must be in 1..15");
    end

    logic [1:0]   ptr;
    logic         can_acc;
    logic         found;
    logic [1:0]   win;
    logic         grant;
    logic [W-1:0] mux_data;

    assign can_acc = !out_valid | out_ready;

    // First requester at or after ptr, wrapping mod 4.
    always_comb begin
        found = 1'b0;
        win   = ptr;
        for (int k = 0; k < 4; k++) begin
            if (!found && req[ptr + 2'(k)]) begin
                found = 1'b1;
                win   = ptr + 2'(k);
            end
        end
    end

    assign grant = can_acc && found && !rst;
    assign gnt   = grant ? (4'b0001 << win) : 4'b0000;

    always_comb begin
        case (win)
            2'd0:    mux_data = d0;
            2'd1:    mux_data = d1;
            2'd2:    mux_data = d2;
            default: mux_data = d3;
        endcase
    end

`ifdef ARB_BURST_EN
    // While a burst is open ptr parks on the owner, so the normal scan keeps
    // giving it priority; a non-zero count marks the burst as open.
    logic [3:0] burst_cnt;
    logic [3:0] cnt_next;

    assign cnt_next = (win == ptr && burst_cnt != 4'd0) ? burst_cnt + 4'd1 : 4'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr       <= 2'd0;
            burst_cnt <= 4'd0;
        end else if (grant) begin
            if (cnt_next == 4'(MAX_BURST)) begin
                ptr       <= win + 2'd1;
                burst_cnt <= 4'd0;
            end else begin
                ptr       <= win;
                burst_cnt <= cnt_next;
            end
        end else if (can_acc && burst_cnt != 4'd0 && !req[ptr]) begin
            ptr       <= ptr + 2'd1;
            burst_cnt <= 4'd0;
        end
    end
`else
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= 2'd0;
        end else if (grant) begin
            ptr <= win + 2'd1;
        end
    end
`endif

    // A new beat may load in the same cycle the held one drains.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= 2'd0;
        end else if (grant) begin
            out_valid <= 1'b1;
            out_data  <= mux_data;
            out_src   <= win;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
